// File: rtl/fetch_pkg.sv
// Shared opcodes, default no-op word and fetch FSM state encoding.
package fetch_pkg;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] OPC_J     = 5'b00001;
  localparam logic [4:0] OPC_JAL   = 5'b00011;

  localparam logic [31:0] NOP_INS_DEF = {OPC_RTYPE, 27'd0};

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Unconditional direct jumps that fetch may follow without waiting for decode
  function automatic logic is_jump(input logic [31:0] ins);
    return (ins[31:27] == OPC_J) || (ins[31:27] == OPC_JAL);
  endfunction

endpackage

// File: rtl/fetch_stage_fd_latch.sv
// F/D pipeline register: flush beats load, otherwise hold.
module fd_latch
  import fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32,
  parameter logic [31:0] NOP_INS  = NOP_INS_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic                flush,
  input  logic [31:0]         ins,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                predecoded,
  output logic [31:0]         fd_ins,
  output logic [PC_WIDTH-1:0] fd_pc,
  output logic                fd_valid,
  output logic                fd_predecoded
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fd_ins        <= NOP_INS;
      fd_pc         <= '0;
      fd_valid      <= 1'b0;
      fd_predecoded <= 1'b0;
    end else if (flush) begin
      fd_ins        <= NOP_INS;
      fd_valid      <= 1'b0;
      fd_predecoded <= 1'b0;
    end else if (load) begin
      fd_ins        <= ins;
      fd_pc         <= pc;
      fd_valid      <= 1'b1;
      fd_predecoded <= predecoded;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, ROM address select, in-flight tracking and F/D load.
// Optional fetch-side jump following enabled by FETCH_JUMP_PREDECODE_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 32,
  parameter int unsigned         IMEM_AW  = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]         NOP_INS  = NOP_INS_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [31:0]         imem_ins,
  output logic [31:0]         fd_ins,
  output logic [PC_WIDTH-1:0] fd_pc,
  output logic                fd_valid,
  output logic                fd_predecoded
);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [PC_WIDTH-1:0] sel_pc;
  logic [PC_WIDTH-1:0] jump_target;
  logic                jump_hit;
  logic                fd_load;
  logic                fd_flush;

`ifdef FETCH_JUMP_PREDECODE_EN
  assign jump_hit    = (state_q == STREAM) && !stall && !redirect && is_jump(imem_ins);
  assign jump_target = PC_WIDTH'(imem_ins[26:0]);
`else
  assign jump_hit    = 1'b0;
  assign jump_target = '0;
`endif

  // Address select and next-state; stall in STREAM re-reads the pending word
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    sel_pc   = pc_q;
    fd_load  = 1'b0;
    fd_flush = 1'b0;
    if (redirect) begin
      sel_pc   = redirect_pc;
      pc_d     = redirect_pc + PC_WIDTH'(1);
      rsp_pc_d = redirect_pc;
      state_d  = STREAM;
      fd_flush = 1'b1;
    end else if (stall) begin
      sel_pc = (state_q == STREAM) ? rsp_pc_q : pc_q;
    end else begin
      sel_pc   = jump_hit ? jump_target : pc_q;
      pc_d     = sel_pc + PC_WIDTH'(1);
      rsp_pc_d = sel_pc;
      state_d  = STREAM;
      if (state_q == STREAM) fd_load = 1'b1;
      else fd_flush = 1'b1;
    end
  end

  assign imem_addr = sel_pc[IMEM_AW-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      rsp_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
    end
  end

  fd_latch #(
    .PC_WIDTH (PC_WIDTH),
    .NOP_INS  (NOP_INS)
  ) u_fd_latch (
    .clock         (clock),
    .reset         (reset),
    .load          (fd_load),
    .flush         (fd_flush),
    .ins           (imem_ins),
    .pc            (rsp_pc_q + PC_WIDTH'(1)),
    .predecoded    (jump_hit),
    .fd_ins        (fd_ins),
    .fd_pc         (fd_pc),
    .fd_valid      (fd_valid),
    .fd_predecoded (fd_predecoded)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected F/D words, monitor pops.
module tb_fetch_stage;

  localparam int unsigned PW = 32;
  localparam int unsigned AW = 12;

  typedef struct packed {
    logic [31:0]   ins;
    logic [PW-1:0] pc;
    logic          pred;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [PW-1:0] redirect_pc = '0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_ins = '0;
  logic [31:0]   fd_ins;
  logic [PW-1:0] fd_pc;
  logic          fd_valid;
  logic          fd_predecoded;

  int   tests = 0;
  int   fails = 0;
  logic jrom  = 1'b0;
  exp_t sb[$];

  fetch_stage dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_ins      (imem_ins),
    .fd_ins        (fd_ins),
    .fd_pc         (fd_pc),
    .fd_valid      (fd_valid),
    .fd_predecoded (fd_predecoded)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom(input logic [AW-1:0] a);
    if (jrom && a == AW'(3)) return 32'h0800_0020;
    return 32'h1000_0000 + 32'(a);
  endfunction

  always @(posedge clock) imem_ins <= rom(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] ins, input logic [PW-1:0] pc, input logic pred);
    exp_t e;
    e.ins = ins; e.pc = pc; e.pred = pred;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic s, input logic r, input logic [PW-1:0] rp, input logic [AW-1:0] exp_addr);
    @(negedge clock);
    stall = s; redirect = r; redirect_pc = rp;
    #1 chk("imem_addr", 32'(imem_addr), 32'(exp_addr));
  endtask

  // Monitor: a load is presented after each edge where downstream was not stalled
  always begin
    logic take;
    exp_t e;
    @(posedge clock);
    take = !stall;
    #1;
    if (take && fd_valid) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_fd: got fd_ins %08h fd_pc %0d with empty scoreboard", fd_ins, fd_pc);
      end else begin
        e = sb.pop_front();
        chk("fd_ins", fd_ins, e.ins);
        chk("fd_pc", fd_pc, e.pc);
        chk("fd_predecoded", 32'(fd_predecoded), 32'(e.pred));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_fd_valid", 32'(fd_valid), 32'd0);
    chk("rst_fd_ins", fd_ins, 32'h0);
    chk("rst_fd_pc", fd_pc, 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);

    @(negedge clock);
    reset = 1'b1;
    #1 chk("imem_addr", 32'(imem_addr), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 1'b0, '0, AW'(k));
      push(rom(AW'(k - 1)), PW'(k), 1'b0);
    end

    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, '0, AW'(5));
      chk("stall_fd_ins", fd_ins, rom(AW'(4)));
      chk("stall_fd_pc", fd_pc, 32'd5);
    end
    cyc(1'b0, 1'b0, '0, AW'(6)); push(rom(AW'(5)), 6, 1'b0);
    cyc(1'b0, 1'b0, '0, AW'(7)); push(rom(AW'(6)), 7, 1'b0);

    cyc(1'b0, 1'b1, 40, AW'(40));
    @(negedge clock);
    chk("redir_fd_valid", 32'(fd_valid), 32'd0);
    chk("redir_fd_ins", fd_ins, 32'h0);
    stall = 1'b0; redirect = 1'b0;
    #1 chk("imem_addr", 32'(imem_addr), 32'd41);
    push(rom(AW'(40)), 41, 1'b0);
    cyc(1'b0, 1'b0, '0, AW'(42)); push(rom(AW'(41)), 42, 1'b0);

    cyc(1'b1, 1'b1, 100, AW'(100));
    @(negedge clock);
    chk("redir_stall_fd_valid", 32'(fd_valid), 32'd0);
    chk("redir_stall_fd_ins", fd_ins, 32'h0);
    stall = 1'b0; redirect = 1'b0;
    #1 chk("imem_addr", 32'(imem_addr), 32'd101);
    push(rom(AW'(100)), 101, 1'b0);
    cyc(1'b0, 1'b0, '0, AW'(102)); push(rom(AW'(101)), 102, 1'b0);

    cyc(1'b0, 1'b1, 19, AW'(19));
    cyc(1'b0, 1'b0, '0, AW'(20));
    reset = 1'b0;
    #1;
    chk("midrst_imem_addr", 32'(imem_addr), 32'd0);
    chk("midrst_fd_valid", 32'(fd_valid), 32'd0);
    chk("midrst_fd_ins", fd_ins, 32'h0);
    chk("midrst_fd_pc", fd_pc, 32'd0);
    chk("midrst_fd_pred", 32'(fd_predecoded), 32'd0);

    jrom = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("imem_addr", 32'(imem_addr), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 1'b0, '0, AW'(k));
      push(rom(AW'(k - 1)), PW'(k), 1'b0);
    end
`ifdef FETCH_JUMP_PREDECODE_EN
    cyc(1'b0, 1'b0, '0, AW'(32)); push(32'h0800_0020, 4, 1'b1);
    cyc(1'b0, 1'b0, '0, AW'(33)); push(rom(AW'(32)), 33, 1'b0);
    cyc(1'b0, 1'b0, '0, AW'(34)); push(rom(AW'(33)), 34, 1'b0);
`else
    cyc(1'b0, 1'b0, '0, AW'(4)); push(32'h0800_0020, 4, 1'b0);
    cyc(1'b0, 1'b0, '0, AW'(5)); push(rom(AW'(4)), 5, 1'b0);
    cyc(1'b0, 1'b0, '0, AW'(6)); push(rom(AW'(5)), 6, 1'b0);
`endif

    @(negedge clock);
    stall = 1'b1;
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
